serial_subtractor_8bit: RTL and testbench
=========================================

Name: serial_subtractor_8bit

Overview:
Bit-serial 8-bit two's-complement subtractor. It is the inverse-operation companion to the team's ripple-carry 8-bit adder. One full-subtractor cell is reused across 8 cycles, and a registered borrow carries between bits. Operands enter and results leave through valid/ready handshakes; the block sits between operand producers and result consumers in the datapath.

Parameters:
WIDTH, 8, operand/result width; the counter width is derived as clog2(WIDTH). Only 8 is verified.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a, b, bin are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow-in.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
diff  output  WIDTH  result a − b − bin, mod 2^WIDTH.
bout  output  1  borrow-out; 1 when unsigned a < b + bin.
ovf  output  1  signed overflow; 1 when signed a − b − bin is outside [−128, 127].

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; bit counter, borrow register, operand shift registers, diff, bout and ovf all clear to 0.
  - out_valid = 0 and in_ready = 1, because both are decoded from state.
  - Reset mid-CALC or mid-DONE aborts the operation; no partial result is ever flagged valid.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid = 1, the operands are captured: a_sh ← a, b_sh ← b, borrow ← bin, cnt ← 0, diff ← 0. State goes to CALC.
  - in_valid low means stay in IDLE.
- CALC (in_ready = 0, out_valid = 0). On each edge:
  - d = a_sh[0] ^ b_sh[0] ^ borrow.
  - borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
  - diff shifts right with d entering at the MSB; a_sh and b_sh shift right; cnt increments.
  - When cnt = 7, on that edge: diff is complete, bout ← borrow_next, ovf ← (a[7] ≠ b[7]) & (diff[7] ≠ a[7]), using the captured sign bits. State goes to DONE.
- DONE:
  - out_valid = 1; diff, bout and ovf are held stable.
  - On an edge with out_ready = 1, go to IDLE. diff, bout and ovf keep their values but are meaningless while out_valid = 0.
  - out_ready low means hold indefinitely.
- Latency: acceptance edge E. Bits 0..7 compute on edges E+1..E+8, so out_valid is high from edge E+8. Minimum spacing between accepts is 10 edges.
- in_valid is ignored outside IDLE; operands presented there are not captured, and the producer must hold them per the handshake.
- in_valid and out_ready are only sampled in their respective states. Simultaneous out_ready in DONE and in_valid does not capture; the new operand is accepted on the next IDLE edge.
- Operand inputs may change freely after acceptance; the captured copies are used.
- No X propagation from unused inputs while idle.

Test Plan:
- Basic subtraction: a = 0x05, b = 0x03, bin = 0, accept on edge E -> out_valid rises at E+8; diff = 0x02, bout = 0, ovf = 0; in_ready = 0 from E through the out handshake.
- Unsigned underflow: a = 0x00, b = 0x01, bin = 0 -> diff = 0xFF, bout = 1, ovf = 0.
- Signed overflow: a = 0x80, b = 0x01, bin = 0 -> diff = 0x7F, bout = 0, ovf = 1. Also a = 0x7F, b = 0xFF, bin = 0 -> diff = 0x80, bout = 1, ovf = 1.
- Borrow-in: a = 0xFF, b = 0xFF, bin = 1 -> diff = 0xFF, bout = 1, ovf = 0. Also a = 0x10, b = 0x00, bin = 1 -> diff = 0x0F, bout = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while driving in_valid = 1 with a = 0xAA -> diff, bout and ovf are stable, in_ready = 0, the new operand is not captured. Then out_ready = 1 -> IDLE next edge, and the 0xAA operand is accepted on the following edge.
- Reset mid-operation: assert rst_n = 0 asynchronously after 4 CALC edges -> out_valid = 0, in_ready = 1, diff = 0 immediately. After release, a = 0x3C, b = 0x0F gives diff = 0x2D, bout = 0, ovf = 0.

Source files
------------

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell reused for
// WIDTH cycles, with a registered borrow chaining the bits LSB first.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             a_sign_q;
    logic             b_sign_q;

    logic             d_bit;
    logic             borrow_d;
    logic [WIDTH-1:0] diff_d;
    logic             last_bit;

    // Full-subtractor cell operating on the current LSBs of the shift registers.
    always_comb begin
        d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
        borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
        diff_d   = {d_bit, diff_q[WIDTH-1:1]};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        borrow_q <= bin;
                        a_sign_q <= a[WIDTH-1];
                        b_sign_q <= b[WIDTH-1];
                        cnt_q    <= '0;
                        diff_q   <= '0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    diff_q   <= diff_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // d_bit is the result sign bit on this final edge.
                        bout_q  <= borrow_d;
                        ovf_q   <= (a_sign_q != b_sign_q) & (d_bit != a_sign_q);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Scoreboard bench for serial_subtractor_8bit: driver pushes arithmetic
// expectations, an independent monitor pops them when a result appears.
module tb_serial_subtractor_8bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   n_checks    = 0;
    int   cyc         = 0;
    bit   rand_rdy    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        exp_t e;
        int   su;
        int   ss;
        su = int'(av) - int'(bv) - int'(bi);
        ss = int'($signed(av)) - int'($signed(bv)) - int'(bi);
        e.d       = su[7:0];
        e.bo      = (su < 0);
        e.ov      = (ss < -128) || (ss > 127);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        output int acc);
        int   w;
        exp_t e;
        w        = 0;
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(negedge clk);
        acc       = cyc;
        e         = model(av, bv, bi);
        e.acc_cyc = acc;
        sb.push_back(e);
        vectors++;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        bin      = 1'($urandom);
        chk("in_ready_calc", 32'(in_ready), 32'd0);
        $display("vec %0d: a=%02h b=%02h bin=%0d accepted at edge %0d", vectors, av, bv, bi, acc);
    endtask

    // Monitor: first cycle of out_valid pops and compares; later cycles check stability.
    bit         seen = 0;
    logic [9:0] held;
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_ready && out_valid) chk("ready_valid_exclusive", 32'd1, 32'd0);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    held = {diff, bout, ovf};
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("diff", 32'(diff), 32'(e.d));
                        chk("bout", 32'(bout), 32'(e.bo));
                        chk("ovf", 32'(ovf), 32'(e.ov));
                        chk("latency", 32'(cyc), 32'(e.acc_cyc + 8));
                        $display("res: diff=%02h bout=%0d ovf=%0d (exp %02h %0d %0d) at edge %0d",
                                 diff, bout, ovf, e.d, e.bo, e.ov, cyc);
                    end
                end else begin
                    chk("hold_stable", 32'({diff, bout, ovf}), 32'(held));
                end
            end else begin
                seen = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [7:0] da [6] = '{8'h05, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h10};
    logic [7:0] db [6] = '{8'h03, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h00};
    logic       dbi[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int acc;
        int c0;
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        bin       = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) send(da[i], db[i], dbi[i], acc);

        // Backpressure: result held while a new operand waits at the input.
        w = 0;
        while (in_ready == 1'b0 && w < 40) begin @(negedge clk); w++; end
        out_ready = 1'b0;
        send(8'h05, 8'h03, 1'b0, acc);
        w = 0;
        while (!out_valid && w < 20) begin @(negedge clk); w++; end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        a        = 8'hAA;
        b        = 8'h55;
        bin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        c0 = cyc;
        send(8'hAA, 8'h55, 1'b0, acc);
        chk("bp_accept_edge", 32'(acc), 32'(c0 + 2));

        // Asynchronous reset after four CALC edges.
        repeat (12) @(negedge clk);
        send(8'h12, 8'h34, 1'b1, acc);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_diff", 32'(diff), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h3C, 8'h0F, 1'b0, acc);

        // Randomized traffic with random consumer backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(8'($urandom), 8'($urandom), 1'($urandom), acc);
        end

        w = 0;
        while (sb.size() != 0 && w < 200) begin @(negedge clk); w++; end
        chk("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
